reg_map: RTL and testbench

- Memory-mapped configuration/status register block for the serial interface (USI) peripheral.
- Sits between the system bus, through the `bus_protocol_if` interface, and the protocol control unit.
- Holds mode select, clock divider, protocol parameters and TX data; exposes RX buffer data and the error status to the bus.
- Flags bus accesses to unmapped addresses.

---
 rtl/reg_map.sv | 182 ++++++++++++++++++
 tb/tb_reg_map.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_map.sv
// ---------------------------------------------------------------------------
// reg_map
//
// Purpose:
//   Memory-mapped configuration and status register block for the USI serial
//   peripheral. It sits between the system bus and the protocol control unit.
//   It holds the mode select, clock divider, protocol parameter word and TX
//   data word. It also exposes the RX buffer word and the error status to the
//   bus, and flags any bus access to an unmapped address.
//
// Register map (byte offsets, full 32-bit compare, word aligned only):
//   0x00  mode_sel     RW  bits[1:0], reads zero-extended
//   0x04  clkdiv       RW
//   0x08  parameters   RW
//   0x0C  tx_data      RW
//   0x10  buffer_read  RO  (writes silently ignored)
//   0x14  error_reg    RO  (writes silently ignored)
//
// Ports:
//   CLK                 in   system clock, rising edge
//   nRST                in   asynchronous active-low reset
//   bpif_wen            in   bus write enable
//   bpif_ren            in   bus read enable
//   bpif_addr[31:0]     in   bus byte address
//   bpif_wdata[31:0]    in   bus write data
//   bpif_strobe[3:0]    in   byte-lane enables, bit i -> wdata[8i+7:8i]
//   bpif_rdata[31:0]    out  combinational read data (0 when ren=0)
//   bpif_error          out  registered one-cycle pulse after unmapped access
//   bpif_request_stall  out  always 0, every access completes in its cycle
//   ctrl_unit_error     in   error indication from the control unit
//   mode_sel[1:0]       out  protocol mode select
//   clkdiv[31:0]        out  clock divider value
//   parameters[31:0]    out  protocol parameter word
//   tx_data[31:0]       out  transmit data word
//   error_reg[31:0]     out  registered error status {31'b0, ctrl_unit_error}
//   buffer_read[31:0]   in   RX buffer word from the control unit
// ---------------------------------------------------------------------------
module reg_map (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        bpif_wen,
    input  logic        bpif_ren,
    input  logic [31:0] bpif_addr,
    input  logic [31:0] bpif_wdata,
    input  logic [3:0]  bpif_strobe,
    output logic [31:0] bpif_rdata,
    output logic        bpif_error,
    output logic        bpif_request_stall,
    input  logic        ctrl_unit_error,
    output logic [1:0]  mode_sel,
    output logic [31:0] clkdiv,
    output logic [31:0] parameters,
    output logic [31:0] tx_data,
    output logic [31:0] error_reg,
    input  logic [31:0] buffer_read
);

    localparam logic [31:0] ADDR_MODE_SEL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_CLKDIV     = 32'h0000_0004;
    localparam logic [31:0] ADDR_PARAMETERS = 32'h0000_0008;
    localparam logic [31:0] ADDR_TX_DATA    = 32'h0000_000C;
    localparam logic [31:0] ADDR_BUFFER     = 32'h0000_0010;
    localparam logic [31:0] ADDR_ERROR      = 32'h0000_0014;

    logic [1:0]  r_mode_sel;
    logic [31:0] r_clkdiv;
    logic [31:0] r_parameters;
    logic [31:0] r_tx_data;
    logic [31:0] r_error_reg;
    logic        r_bus_error;

    logic        w_sel_mode_sel;
    logic        w_sel_clkdiv;
    logic        w_sel_parameters;
    logic        w_sel_tx_data;
    logic        w_sel_buffer;
    logic        w_sel_error;
    logic        w_mapped;
    logic        w_access;
    logic [31:0] w_rdata;

    // Replaces only the strobe-enabled byte lanes of a register image.
    function automatic logic [31:0] mergeLanes(
        input logic [31:0] oldValue,
        input logic [31:0] newValue,
        input logic [3:0]  strobe
    );
        logic [31:0] result;
        result = oldValue;
        for (int lane = 0; lane < 4; lane++) begin
            if (strobe[lane]) begin
                result[lane*8 +: 8] = newValue[lane*8 +: 8];
            end
        end
        return result;
    endfunction

    // Full 32-bit address compare, so misaligned offsets such as 0x05 fall
    // through to unmapped along with everything outside the map.
    assign w_sel_mode_sel   = (bpif_addr == ADDR_MODE_SEL);
    assign w_sel_clkdiv     = (bpif_addr == ADDR_CLKDIV);
    assign w_sel_parameters = (bpif_addr == ADDR_PARAMETERS);
    assign w_sel_tx_data    = (bpif_addr == ADDR_TX_DATA);
    assign w_sel_buffer     = (bpif_addr == ADDR_BUFFER);
    assign w_sel_error      = (bpif_addr == ADDR_ERROR);

    assign w_mapped = w_sel_mode_sel | w_sel_clkdiv | w_sel_parameters |
                      w_sel_tx_data  | w_sel_buffer | w_sel_error;
    assign w_access = bpif_wen | bpif_ren;

    // Writable configuration registers. A write with strobe 0 leaves every
    // lane alone, which naturally gives "no change" without special casing.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mode_sel   <= 2'b00;
            r_clkdiv     <= 32'h0;
            r_parameters <= 32'h0;
            r_tx_data    <= 32'h0;
        end else if (bpif_wen) begin
            if (w_sel_mode_sel && bpif_strobe[0]) begin
                r_mode_sel <= bpif_wdata[1:0];
            end
            if (w_sel_clkdiv) begin
                r_clkdiv <= mergeLanes(r_clkdiv, bpif_wdata, bpif_strobe);
            end
            if (w_sel_parameters) begin
                r_parameters <= mergeLanes(r_parameters, bpif_wdata, bpif_strobe);
            end
            if (w_sel_tx_data) begin
                r_tx_data <= mergeLanes(r_tx_data, bpif_wdata, bpif_strobe);
            end
        end
    end

    // Error status is a plain one-cycle-delayed copy of the control unit flag,
    // deliberately non-sticky so software sees the live condition.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_error_reg <= 32'h0;
        end else begin
            r_error_reg <= {31'b0, ctrl_unit_error};
        end
    end

    // Bus error is re-evaluated every edge, so it stays high for exactly one
    // cycle per offending access unless unmapped accesses arrive back to back.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_bus_error <= 1'b0;
        end else begin
            r_bus_error <= w_access & ~w_mapped;
        end
    end

    // Read mux is purely combinational, so a simultaneous write shows the
    // pre-write register contents in the same cycle.
    always_comb begin
        w_rdata = 32'h0;
        if (bpif_ren) begin
            unique case (1'b1)
                w_sel_mode_sel:   w_rdata = {30'b0, r_mode_sel};
                w_sel_clkdiv:     w_rdata = r_clkdiv;
                w_sel_parameters: w_rdata = r_parameters;
                w_sel_tx_data:    w_rdata = r_tx_data;
                w_sel_buffer:     w_rdata = buffer_read;
                w_sel_error:      w_rdata = r_error_reg;
                default:          w_rdata = 32'h0;
            endcase
        end
    end

    assign bpif_rdata         = w_rdata;
    assign bpif_error         = r_bus_error;
    assign bpif_request_stall = 1'b0;

    assign mode_sel   = r_mode_sel;
    assign clkdiv     = r_clkdiv;
    assign parameters = r_parameters;
    assign tx_data    = r_tx_data;
    assign error_reg  = r_error_reg;

endmodule

// File: tb/tb_reg_map.sv
// ---------------------------------------------------------------------------
// tb_reg_map
//
// Directed testbench for reg_map. Inputs change on the falling edge, and
// registered outputs are sampled 1ns after the rising edge. Combinational
// read data is sampled 1ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_reg_map;

    logic        CLK;
    logic        nRST;
    logic        bpif_wen;
    logic        bpif_ren;
    logic [31:0] bpif_addr;
    logic [31:0] bpif_wdata;
    logic [3:0]  bpif_strobe;
    logic [31:0] bpif_rdata;
    logic        bpif_error;
    logic        bpif_request_stall;
    logic        ctrl_unit_error;
    logic [1:0]  mode_sel;
    logic [31:0] clkdiv;
    logic [31:0] parameters;
    logic [31:0] tx_data;
    logic [31:0] error_reg;
    logic [31:0] buffer_read;

    int checks;
    int errors;

    reg_map dut (
        .CLK                (CLK),
        .nRST               (nRST),
        .bpif_wen           (bpif_wen),
        .bpif_ren           (bpif_ren),
        .bpif_addr          (bpif_addr),
        .bpif_wdata         (bpif_wdata),
        .bpif_strobe        (bpif_strobe),
        .bpif_rdata         (bpif_rdata),
        .bpif_error         (bpif_error),
        .bpif_request_stall (bpif_request_stall),
        .ctrl_unit_error    (ctrl_unit_error),
        .mode_sel           (mode_sel),
        .clkdiv             (clkdiv),
        .parameters         (parameters),
        .tx_data            (tx_data),
        .error_reg          (error_reg),
        .buffer_read        (buffer_read)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one write cycle and returns 1ns after the capturing edge.
    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        @(negedge CLK);
        bpif_wen    = 1'b1;
        bpif_addr   = addr;
        bpif_wdata  = data;
        bpif_strobe = strb;
        @(posedge CLK);
        #1;
        bpif_wen    = 1'b0;
        bpif_strobe = 4'h0;
    endtask

    // Starts a read on the falling edge; the caller checks rdata, then
    // calls busIdle to end the access.
    task automatic busReadStart(input logic [31:0] addr);
        @(negedge CLK);
        bpif_ren  = 1'b1;
        bpif_addr = addr;
        #1;
    endtask

    task automatic busIdle();
        bpif_ren = 1'b0;
        bpif_wen = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST            = 1'b0;
        bpif_wen        = 1'b0;
        bpif_ren        = 1'b0;
        bpif_addr       = 32'h0;
        bpif_wdata      = 32'h0;
        bpif_strobe     = 4'h0;
        ctrl_unit_error = 1'b0;
        buffer_read     = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({mode_sel, clkdiv, parameters, tx_data, error_reg, bpif_error} !== 131'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got mode=%h clkdiv=%h par=%h tx=%h err=%h berr=%b, expected all 0",
                     mode_sel, clkdiv, parameters, tx_data, error_reg, bpif_error);
        end
        checks++;
        if (bpif_request_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL request_stall: got %b expected 0", bpif_request_stall);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_mode_write();
        busWrite(32'h00, 32'h0000_0002, 4'b0001);
        checks++;
        if (mode_sel !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mode_sel_write: got %0d expected 2", mode_sel);
        end
        busReadStart(32'h00);
        checks++;
        if (bpif_rdata !== 32'h0000_0002) begin
            errors++;
            $display("[TB] FAIL mode_sel_read: got %h expected 00000002", bpif_rdata);
        end
        busIdle();
        // Lane 0 disabled: mode_sel must hold its value.
        busWrite(32'h00, 32'h0000_0001, 4'b1110);
        checks++;
        if (mode_sel !== 2'd2) begin
            errors++;
            $display("[TB] FAIL mode_sel_lane0_off: got %0d expected 2", mode_sel);
        end
    endtask

    task automatic test_full_writes();
        busWrite(32'h04, 32'h1234_5678, 4'b1111);
        busWrite(32'h08, 32'hAAAA_AAAA, 4'b1111);
        busWrite(32'h0C, 32'hBBBB_BBBB, 4'b1111);
        checks++;
        if (clkdiv !== 32'h1234_5678 || parameters !== 32'hAAAA_AAAA || tx_data !== 32'hBBBB_BBBB) begin
            errors++;
            $display("[TB] FAIL full_writes: got clkdiv=%h par=%h tx=%h expected 12345678 aaaaaaaa bbbbbbbb",
                     clkdiv, parameters, tx_data);
        end
        busReadStart(32'h04);
        checks++;
        if (bpif_rdata !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL read_clkdiv: got %h expected 12345678", bpif_rdata);
        end
        bpif_addr = 32'h08;
        #1;
        checks++;
        if (bpif_rdata !== 32'hAAAA_AAAA) begin
            errors++;
            $display("[TB] FAIL read_parameters: got %h expected aaaaaaaa", bpif_rdata);
        end
        busIdle();
        #1;
        checks++;
        if (bpif_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rdata_when_idle: got %h expected 00000000", bpif_rdata);
        end
    endtask

    task automatic test_partial_write();
        busWrite(32'h04, 32'hFFFF_0000, 4'b0011);
        busReadStart(32'h04);
        checks++;
        if (bpif_rdata !== 32'h1234_0000) begin
            errors++;
            $display("[TB] FAIL partial_write: got %h expected 12340000", bpif_rdata);
        end
        busIdle();
        busWrite(32'h08, 32'h5555_5555, 4'b1000);
        checks++;
        if (parameters !== 32'h55AA_AAAA) begin
            errors++;
            $display("[TB] FAIL partial_write_top_lane: got %h expected 55aaaaaa", parameters);
        end
        // Zero strobe to a mapped address: no change and no error.
        busWrite(32'h0C, 32'h0000_0000, 4'b0000);
        checks++;
        if (tx_data !== 32'hBBBB_BBBB || bpif_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_strobe: got tx=%h berr=%b expected bbbbbbbb 0", tx_data, bpif_error);
        end
    endtask

    task automatic test_unmapped();
        busWrite(32'h20, 32'hDEAD_BEEF, 4'b1111);
        checks++;
        if (bpif_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unmapped_error_set: got %b expected 1", bpif_error);
        end
        tick();
        checks++;
        if (bpif_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL unmapped_error_clear: got %b expected 0", bpif_error);
        end
        checks++;
        if (mode_sel !== 2'd2 || clkdiv !== 32'h1234_0000 || parameters !== 32'h55AA_AAAA ||
            tx_data !== 32'hBBBB_BBBB) begin
            errors++;
            $display("[TB] FAIL unmapped_no_change: got mode=%0d clkdiv=%h par=%h tx=%h",
                     mode_sel, clkdiv, parameters, tx_data);
        end
        // Misaligned read: returns 0 and raises the bus error pulse.
        busReadStart(32'h05);
        checks++;
        if (bpif_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL misaligned_rdata: got %h expected 00000000", bpif_rdata);
        end
        tick();
        busIdle();
        checks++;
        if (bpif_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misaligned_error: got %b expected 1", bpif_error);
        end
        tick();
        checks++;
        if (bpif_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misaligned_error_clear: got %b expected 0", bpif_error);
        end
    endtask

    task automatic test_error_status();
        @(negedge CLK);
        ctrl_unit_error = 1'b1;
        #1;
        checks++;
        if (error_reg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL error_reg_latency: got %h expected 00000000", error_reg);
        end
        tick();
        checks++;
        if (error_reg !== 32'h1) begin
            errors++;
            $display("[TB] FAIL error_reg_set: got %h expected 00000001", error_reg);
        end
        busReadStart(32'h14);
        checks++;
        if (bpif_rdata !== 32'h1) begin
            errors++;
            $display("[TB] FAIL read_error_reg_set: got %h expected 00000001", bpif_rdata);
        end
        busIdle();
        tick();
        @(negedge CLK);
        ctrl_unit_error = 1'b0;
        tick();
        busReadStart(32'h14);
        checks++;
        if (bpif_rdata !== 32'h0 || error_reg !== 32'h0) begin
            errors++;
            $display("[TB] FAIL error_reg_clear: got rdata=%h reg=%h expected 0 0", bpif_rdata, error_reg);
        end
        busIdle();
    endtask

    task automatic test_buffer_read();
        @(negedge CLK);
        buffer_read = 32'hCAFE_F00D;
        busReadStart(32'h10);
        checks++;
        if (bpif_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL buffer_read: got %h expected cafef00d", bpif_rdata);
        end
        busIdle();
        busWrite(32'h10, 32'h1111_1111, 4'b1111);
        checks++;
        if (bpif_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ro_write_error: got %b expected 0", bpif_error);
        end
        busReadStart(32'h10);
        checks++;
        if (bpif_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("[TB] FAIL ro_write_unchanged: got %h expected cafef00d", bpif_rdata);
        end
        busIdle();
        busWrite(32'h14, 32'hFFFF_FFFF, 4'b1111);
        checks++;
        if (error_reg !== 32'h0 || bpif_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ro_error_reg_write: got reg=%h berr=%b expected 0 0", error_reg, bpif_error);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        bpif_wen    = 1'b1;
        bpif_ren    = 1'b1;
        bpif_addr   = 32'h0C;
        bpif_wdata  = 32'h1122_3344;
        bpif_strobe = 4'b1111;
        #1;
        checks++;
        if (bpif_rdata !== 32'hBBBB_BBBB) begin
            errors++;
            $display("[TB] FAIL rw_pre_write_value: got %h expected bbbbbbbb", bpif_rdata);
        end
        tick();
        bpif_wen = 1'b0;
        checks++;
        if (tx_data !== 32'h1122_3344 || bpif_rdata !== 32'h1122_3344) begin
            errors++;
            $display("[TB] FAIL rw_post_write: got tx=%h rdata=%h expected 11223344", tx_data, bpif_rdata);
        end
        busIdle();
        // Two unmapped accesses in a row keep the error high for both cycles.
        busWrite(32'h18, 32'h0, 4'b1111);
        busWrite(32'hFFFF_FFFC, 32'h0, 4'b1111);
        checks++;
        if (bpif_error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL back_to_back_error: got %b expected 1", bpif_error);
        end
        tick();
        checks++;
        if (bpif_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_back_error_clear: got %b expected 0", bpif_error);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if ({mode_sel, clkdiv, parameters, tx_data, error_reg, bpif_error} !== 131'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got mode=%h clkdiv=%h par=%h tx=%h err=%h berr=%b, expected all 0",
                     mode_sel, clkdiv, parameters, tx_data, error_reg, bpif_error);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mode_write();
        test_full_writes();
        test_partial_write();
        test_unmapped();
        test_error_status();
        test_buffer_read();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
